alu_mdu: RTL and testbench

- Parametrised-width execute unit: integer ALU with registered output plus an iterative unsigned multiply/divide engine.
- Sits in the execute stage between the ID/IX operand registers and writeback.
- Uses a valid/ready handshake on both sides so multi-cycle ops stall issue.
- Adds flush support for branch mispredict and exceptions.

---
 rtl/alu_mdu.sv | 183 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage integer ALU plus iterative unsigned multiply/divide engine.
// Latency: single-cycle ops and divide-by-zero 1 cycle; MULLO/MULHI/DIVU/REMU WIDTH+1 cycles.
// Backpressure: in_ready only in IDLE or DONE&out_ready; DONE holds result until out_ready.
// Ports: clk/rst (async active-low); in_valid/in_ready/op/a/b issue side;
//        flush abandons the in-flight op; out_valid/out_ready/result/carry/zero/div_by_zero
//        writeback side.
module alu_mdu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;  // counter must hold WIDTH itself

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;    // product high half / remainder
  logic [WIDTH-1:0] lo_q;     // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] opb_q;    // multiplicand / divisor
  logic [1:0]       md_op_q;  // op[1]: divide, op[0]: high half / remainder

  logic accept;
  logic is_md, is_div, b_is_zero, start_iter;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_sum, sub_sum;
  logic [2*WIDTH-1:0] rol_w, ror_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_dbz;

  assign shamt     = b[SHW-1:0];
  assign is_md     = op[3] & op[2];
  assign is_div    = is_md & op[1];
  assign b_is_zero = (b == '0);
  // Divide by zero is resolved by the ALU path in one cycle, never iterated.
  assign start_iter = is_md & ~(is_div & b_is_zero);

  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // Rotates via a doubled operand so an amount of 0 naturally returns a.
    rol_w     = {a, a} << shamt;
    ror_w     = {a, a} >> shamt;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_dbz   = 1'b0;
    case (op)
      4'd0:  begin alu_res = add_sum[WIDTH-1:0]; alu_carry = add_sum[WIDTH]; end
      4'd1:  begin alu_res = sub_sum[WIDTH-1:0]; alu_carry = sub_sum[WIDTH]; end
      4'd2:  alu_res = a ^ b;
      4'd3:  alu_res = a & ~b;
      4'd4:  alu_res = a << shamt;
      4'd5:  alu_res = a >> shamt;
      4'd6:  alu_res = rol_w[2*WIDTH-1:WIDTH];
      4'd7:  alu_res = ror_w[WIDTH-1:0];
      4'd8:  alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
      4'd11: begin alu_res = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]}; alu_carry = add_sum[WIDTH]; end
      4'd14: begin alu_res = '1; alu_dbz = 1'b1; end  // only reached with b == 0
      4'd15: begin alu_res = a;  alu_dbz = 1'b1; end  // only reached with b == 0
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative step: shift-add multiply or restoring divide, one bit per cycle
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] md_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift - {1'b0, opb_q};
    case (md_op_q)
      2'b00:   md_res = lo_q;   // MULLO
      2'b01:   md_res = acc_q;  // MULHI
      2'b10:   md_res = lo_q;   // DIVU
      default: md_res = acc_q;  // REMU
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign accept = in_valid & in_ready & ~flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = start_iter ? BUSY : DONE;
      BUSY: if (cnt_q == '0) state_d = DONE;
      DONE: begin
        if (accept)         state_d = start_iter ? BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      md_op_q     <= '0;
      result      <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (start_iter) begin
        cnt_q   <= CW'(WIDTH);
        acc_q   <= '0;
        lo_q    <= a;
        opb_q   <= b;
        md_op_q <= op[1:0];
      end else begin
        result      <= alu_res;
        carry       <= alu_carry;
        zero        <= (alu_res == '0);
        div_by_zero <= alu_dbz;
      end
    end else if ((state_q == BUSY) && !flush) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
        if (md_op_q[1]) begin
          acc_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          lo_q  <= {lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_q <= mul_sum[WIDTH:1];
          lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end else begin
        result      <= md_res;
        carry       <= 1'b0;
        zero        <= (md_res == '0);
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .zero(zero),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         d;
    int           lat;  // posedges after the accept edge before out_valid is seen
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] r, input logic c, input logic z,
                         input logic d, input int lat);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.res = r; v.c = c; v.z = z; v.d = d; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns 1ns after the accept edge with operands scrambled.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    bit ok = 1'b0;
    in_valid = 1'b1; op = o; a = va; b = vb;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    #1;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  // Counts edges from the accept edge until out_valid; flags in_ready while waiting.
  task automatic wait_valid(output int lat, output bit rdy_seen);
    lat = 0; rdy_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    bit rdy_seen;
    logic [W-1:0] held_res;
    logic held_c, held_z;
    bit seen;

    // Single-cycle ops
    add_vec(4'd0,  16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
    add_vec(4'd1,  16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0, 1'b0, 0);
    add_vec(4'd1,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
    add_vec(4'd2,  16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd3,  16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd4,  16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd4,  16'h8001, 16'h0011, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd5,  16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd5,  16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd6,  16'h8001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd6,  16'h1234, 16'h0004, 16'h2341, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd7,  16'h8001, 16'h0011, 16'hC000, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd7,  16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd8,  16'h0005, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd8,  16'h0005, 16'h0006, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
    add_vec(4'd9,  16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd9,  16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
    add_vec(4'd10, 16'h8000, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'd10, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
    add_vec(4'd11, 16'hFFFF, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 0);
    add_vec(4'd11, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
    add_vec(4'd14, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 0);
    add_vec(4'd15, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b1, 0);
    // Iterative ops: out_valid WIDTH+1 edges after the accept edge
    add_vec(4'd12, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, W+1);
    add_vec(4'd13, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b0, W+1);
    add_vec(4'd12, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0, W+1);
    add_vec(4'd13, 16'h0100, 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b0, W+1);
    add_vec(4'd14, 16'd100,  16'd7,    16'd14,   1'b0, 1'b0, 1'b0, W+1);
    add_vec(4'd15, 16'd100,  16'd7,    16'd2,    1'b0, 1'b0, 1'b0, W+1);
    add_vec(4'd14, 16'd5,    16'd9,    16'd0,    1'b0, 1'b1, 1'b0, W+1);
    add_vec(4'd15, 16'd5,    16'd9,    16'd5,    1'b0, 1'b0, 1'b0, W+1);
    add_vec(4'd14, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, W+1);
    add_vec(4'd15, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, W+1);

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {29'd0, carry, zero, div_by_zero}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat, rdy_seen);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("v%0d_flags", i), {29'd0, carry, zero, div_by_zero},
          {29'd0, vecs[i].c, vecs[i].z, vecs[i].d});
      if (vecs[i].lat != 0) chk($sformatf("v%0d_busy_rdy", i), 32'(rdy_seen), 32'd0);
    end

    // Back-to-back: ADD result consumed while SUB is accepted, no bubble
    @(negedge clk);
    issue(4'd0, 16'hFFFF, 16'h0001);
    @(negedge clk);
    chk("b2b_add_valid", 32'(out_valid), 32'd1);
    chk("b2b_add_result", 32'(result), 32'h0000);
    chk("b2b_add_cz", {30'd0, carry, zero}, 32'd3);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    issue(4'd1, 16'h0005, 16'h0007);
    @(negedge clk);
    chk("b2b_sub_valid", 32'(out_valid), 32'd1);
    chk("b2b_sub_result", 32'(result), 32'hFFFE);
    chk("b2b_sub_carry", 32'(carry), 32'd0);

    // Stall: out_ready low holds the result
    @(negedge clk);
    out_ready = 1'b0;
    issue(4'd0, 16'h1234, 16'h0001);
    @(negedge clk);
    held_res = result; held_c = carry; held_z = zero;
    chk("hold_result0", 32'(held_res), 32'h1235);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_result", k), 32'(result), 32'h1235);
      chk($sformatf("hold%0d_cz", k), {30'd0, carry, zero}, {30'd0, held_c, held_z});
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'd2; a = 16'h00FF; b = 16'h0F0F;
    #1 chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("release_xor_valid", 32'(out_valid), 32'd1);
    chk("release_xor_result", 32'(result), 32'h0FF0);

    // Flush 5 cycles into a MULLO
    @(negedge clk);
    issue(4'd12, 16'h0003, 16'h0005);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (25) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    issue(4'd0, 16'd2, 16'd3);
    wait_valid(lat, rdy_seen);
    chk("post_flush_lat", 32'(lat), 32'd0);
    chk("post_flush_result", 32'(result), 32'd5);

    // Reset mid-DIVU
    @(negedge clk);
    issue(4'd14, 16'd100, 16'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", {29'd0, carry, zero, div_by_zero}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
